// File: rtl/case_char_fifo.sv
// case_char_fifo: show-ahead FIFO holding converted chars with their cap flag.
// Define CASE_CHAR_FIFO_STATS_EN to add saturating cap/small push counters.
module case_char_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_cap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_cap,
`ifdef CASE_CHAR_FIFO_STATS_EN
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic [CNT_W-1:0]  cap_total,
  output logic [CNT_W-1:0]  small_total
`else
  output logic [ADDR_W:0]   level,
  output logic              ovf
`endif
);

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

  logic [8:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_ovf;
  logic              w_push;
  logic              w_pop;
  logic [8:0]        w_head;

  assign in_ready  = (r_level != LP_FULL);
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign out_char  = out_valid ? w_head[7:0] : 8'h00;
  assign out_cap   = out_valid & w_head[8];
  assign level     = r_level;
  assign ovf       = r_ovf;

  // Storage is deliberately left unreset; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= {in_cap, in_char};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
      if (in_valid && !in_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef CASE_CHAR_FIFO_STATS_EN
  logic [CNT_W-1:0] r_cap_total;
  logic [CNT_W-1:0] r_small_total;

  assign cap_total   = r_cap_total;
  assign small_total = r_small_total;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap_total   <= '0;
      r_small_total <= '0;
    end else if (w_push) begin
      if (in_cap && !(&r_cap_total)) begin
        r_cap_total <= r_cap_total + CNT_W'(1);
      end
      if (!in_cap && !(&r_small_total)) begin
        r_small_total <= r_small_total + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/case_char_fifo.md
Name: case_char_fifo

Overview:
- Buffer stage directly downstream of the combinational case converter: captures each converted character (out[7:0]) plus its cap flag.
- Presents characters in order to a consumer over a valid/ready handshake.
- Decouples the converter's source from a consumer that may stall (UART TX, display writer).
- Provides level and sticky overflow status.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
ADDR_W, 3, pointer width; must equal log2(DEPTH)
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  producer offers in_char/in_cap this cycle
in_ready  output  1  FIFO accepts this cycle (= not full)
in_char  input  8  converted character from case converter
in_cap  input  1  converter cap flag (1 = original char was capital)
out_valid  output  1  head entry available (= not empty)
out_ready  input  1  consumer takes head entry this cycle
out_char  output  8  head character; 8'h00 when empty
out_cap  output  1  head cap flag; 0 when empty
level  output  ADDR_W+1  current occupancy, 0..DEPTH
ovf  output  1  sticky: set when in_valid=1 while in_ready=0

Behaviour:
- Single clock domain; all state updates on posedge clk. Reset is synchronous and active-low.
- Reset (rst_n=0 at posedge):
  - wr_ptr, rd_ptr, level and ovf all 0.
  - Hence out_valid=0, out_char=8'h00, out_cap=0, in_ready=1 from the first cycle after reset.
  - Storage array is not reset.
  - Reset has priority over push/pop in the same cycle, including reset mid-stream with data held: all entries are discarded.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (level != DEPTH); out_valid = (level != 0). Both are combinational from level; neither depends on the other side's handshake.
- Push: mem[wr_ptr] <= {in_cap, in_char}; wr_ptr increments modulo DEPTH (natural wrap of ADDR_W bits).
- Pop: rd_ptr increments modulo DEPTH.
- Level update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Show-ahead output: out_char/out_cap reflect mem[rd_ptr] combinationally while out_valid=1; zero when empty.
- Latency: a char pushed into an empty FIFO appears at the output (out_valid=1) in the cycle after the push edge. No same-cycle bypass.
- Full: in_ready=0, so no write occurs. A simultaneous pop still completes; in_ready returns to 1 the following cycle.
- Empty: out_valid=0, so out_ready is ignored. A simultaneous push lands normally.
- Overflow: in_valid=1 with in_ready=0 sets ovf=1 on that edge. The offered data is not stored and the producer is expected to hold. ovf clears only on reset.
- Ordering: strict FIFO; the cap flag always travels with its own character.

Optional Feature:
- Macro: CASE_CHAR_FIFO_STATS_EN
- Defined: adds outputs cap_total[CNT_W-1:0] and small_total[CNT_W-1:0].
  - cap_total increments on each push with in_cap=1; small_total increments on each push with in_cap=0.
  - Both saturate at all-ones (no wrap) and reset to 0.
- Not defined: the ports and counters do not exist. FIFO behaviour is identical in both builds.

Test Plan:
- Reset then idle -> level=0, in_ready=1, out_valid=0, out_char=8'h00, out_cap=0, ovf=0.
- Push 8'h61 cap=1 ('A' converted), out_ready=0 -> next cycle out_valid=1, out_char=8'h61, out_cap=1, level=1.
- Push 'j','r','z','D','V','W','w' (with cap flags 1,1,1,0,0,0,0), out_ready=0:
  - After 8 pushes: level=8, in_ready=0.
  - Extra in_valid=1 -> ovf=1, level stays 8.
  - Drain with out_ready=1 -> 'a','j','r','z','D','V','W','w' in order with cap flags 1,1,1,1,0,0,0,0.
- Full FIFO with in_valid=1 and out_ready=1 together -> head pops, no write that edge; next cycle in_ready=1, level=7. Then continuous push/pop -> level holds 7, pointers wrap past 7 without data corruption.
- Load 3 entries, assert rst_n=0 for one cycle while in_valid=1 and out_ready=1 -> level=0, out_valid=0, ovf=0; next push of 8'h64 appears at the head alone.
- STATS_EN build: push 5 entries with cap=1 and 2 with cap=0 -> cap_total=5, small_total=2. With CNT_W forced to 2, 5 cap pushes -> cap_total=3 (saturated).
